// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the fetch-phase and execute-state encodings used between the control
// unit and the fetch unit, the default instruction width and the NOP encoding.
package inst_fetch_unit_pkg;

    localparam int FE_STATE_BITS = 2;
    localparam int EX_STATE_BITS = 4;
    localparam int INST_WIDTH    = 12;

    localparam logic [11:0] I_NOP_12 = 12'h000;

    typedef enum logic [FE_STATE_BITS-1:0] {
        FE_Q1 = 2'd0,
        FE_Q2 = 2'd1,
        FE_Q3 = 2'd2,
        FE_Q4 = 2'd3
    } feState_t;

    // Only the Q4 states matter to the fetch unit; Q1..Q3 are listed so the
    // encoding space is shared with the control unit.
    typedef enum logic [EX_STATE_BITS-1:0] {
        EX_Q1       = 4'd0,
        EX_Q2       = 4'd1,
        EX_Q3       = 4'd2,
        EX_Q4_ELSE  = 4'd3,
        EX_Q4_GOTO  = 4'd4,
        EX_Q4_CALL  = 4'd5,
        EX_Q4_RETLW = 4'd6,
        EX_Q4_FSZ   = 4'd7,
        EX_Q4_BTFSX = 4'd8
    } exState_t;

endpackage

// File: rtl/inst_fetch_unit_stack2.sv
// pic_stack2: two-level hardware return stack with a saturating depth count.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         store din on top, old top moves down, old bottom is lost
//   pop          bottom moves up to top; bottom keeps its value
//   din          return address to push
//   top          current top-of-stack (return address on pop)
//   depth        valid entries, saturates at 0 and 2
module pic_stack2 #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [1:0]       depth
);

    logic [WIDTH-1:0] stack1;
    logic [WIDTH-1:0] stack2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack1 <= '0;
            stack2 <= '0;
            depth  <= 2'd0;
        end else if (push) begin
            stack2 <= stack1;
            stack1 <= din;
            if (depth != 2'd2) depth <= depth + 2'd1;
        end else if (pop) begin
            // Underflow keeps returning stale contents rather than zero.
            stack1 <= stack2;
            if (depth != 2'd0) depth <= depth - 2'd1;
        end
    end

    assign top = stack1;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: program counter, return stack and instruction register.
// Latches one instruction per 4-phase instruction cycle and redirects the PC
// on GOTO, CALL, RETLW, taken skips and PCL writes; every redirect replaces
// the already-prefetched instruction with a NOP.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   fetchState     fetch phase from control unit (update only in FE_Q4)
//   executeState   execute state from control unit (EX_Q4_* at load edge)
//   romData        program ROM data for romAddr
//   skip           skip condition for FSZ / BTFSx
//   pa             STATUS page bits PA1:PA0
//   pclWrEn        datapath writes PCL, pclData the value
//   romAddr        program ROM address (= pc)
//   instOut        instruction register to control unit
//   stackDepth     valid return-stack entries
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH   = 11,
    parameter int INST_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FE_STATE_BITS-1:0] fetchState,
    input  logic [EX_STATE_BITS-1:0] executeState,
    input  logic [INST_WIDTH-1:0]    romData,
    input  logic                     skip,
    input  logic [1:0]               pa,
    input  logic                     pclWrEn,
    input  logic [7:0]               pclData,
    output logic [PC_WIDTH-1:0]      romAddr,
    output logic [INST_WIDTH-1:0]    instOut,
    output logic [1:0]               stackDepth
);

    localparam logic [PC_WIDTH-1:0]   PC_ONE  = 1;
    localparam logic [INST_WIDTH-1:0] INST_NOP = INST_WIDTH'(I_NOP_12);

    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pcNext;
    logic [PC_WIDTH-1:0]   stackTop;
    logic [INST_WIDTH-1:0] instNext;
    logic                  push;
    logic                  pop;
    logic                  loadEdge;
    logic [10:0]           gotoTarget;
    logic [10:0]           callTarget;
    logic [10:0]           pclTarget;

    assign loadEdge = (fetchState == FE_Q4);

    // Full 11-bit targets; narrower PCs simply drop the upper page bits.
    assign gotoTarget = {pa, instOut[8:0]};
    assign callTarget = {pa, 1'b0, instOut[7:0]};
    assign pclTarget  = {pa, 1'b0, pclData};

    always_comb begin
        pcNext   = pc;
        instNext = instOut;
        push     = 1'b0;
        pop      = 1'b0;
        if (loadEdge) begin
            if (executeState == EX_Q4_GOTO) begin
                pcNext   = gotoTarget[PC_WIDTH-1:0];
                instNext = INST_NOP;
            end else if (executeState == EX_Q4_CALL) begin
                // pc already points past the CALL, so it is the return address.
                push     = 1'b1;
                pcNext   = callTarget[PC_WIDTH-1:0];
                instNext = INST_NOP;
            end else if (executeState == EX_Q4_RETLW) begin
                pop      = 1'b1;
                pcNext   = stackTop;
                instNext = INST_NOP;
            end else if ((executeState == EX_Q4_FSZ || executeState == EX_Q4_BTFSX) && skip) begin
                pcNext   = pc + PC_ONE;
                instNext = INST_NOP;
            end else if (pclWrEn) begin
                pcNext   = pclTarget[PC_WIDTH-1:0];
                instNext = INST_NOP;
            end else begin
                pcNext   = pc + PC_ONE;
                instNext = romData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '1;
            instOut <= INST_NOP;
        end else begin
            pc      <= pcNext;
            instOut <= instNext;
        end
    end

    pic_stack2 #(
        .WIDTH (PC_WIDTH)
    ) uStack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .top   (stackTop),
        .depth (stackDepth)
    );

    assign romAddr = pc;

endmodule
